imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction loader: accepts a framed byte stream (valid/ready), assembles big-endian 32-bit instructions and drives the fetcher's load port (`fetcher_loading`, `fetcher_load_inst`, `chip_select`) while holding the CPU core in reset. It is the producer end of the interface the Astrio core consumes. It sits between the board-level serial/byte source and the CPU top, and releases the core once a complete, valid image has been written.

## Interface
- `MAX_WORDS`, 256: instruction-memory depth in words. Legal frame lengths are 1..MAX_WORDS.
- `SYNC_BYTE`, 8'hA5: frame start marker.

- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `byte_valid`  in  1  source has a byte.
- `byte_data`  in  8  byte payload.
- `byte_ready`  out  1  loader accepts a byte this cycle. A transfer occurs when `byte_valid && byte_ready`.
- `fetcher_loading`  out  1  one-cycle write strobe to the fetcher.
- `fetcher_load_inst`  out  32  assembled instruction; valid when the strobe is high.
- `fetcher_load_addr`  out  32  byte address of the word: word index << 2.
- `chip_select`  out  1  fetcher enable.
- `cpu_rst`  out  1  reset to the CPU core.
- `done`  out  1  image loaded; sticky.
- `error`  out  1  frame rejected; sticky.
- `words_loaded`  out  16  count of strobes issued.

## Operation
- Frame format: `SYNC_BYTE`, then LEN_HI, LEN_LO (16-bit big-endian word count N), then N×4 instruction bytes (MSB first), then CSUM when enabled (see Configuration).
- States:
  - IDLE: `byte_ready`=1. Every byte other than `SYNC_BYTE` is discarded; `SYNC_BYTE` → LEN_HI.
  - LEN_HI → LEN_LO: latch each byte.
  - LEN_LO:
    - If N==0 or N>MAX_WORDS → ERROR.
    - Otherwise → WORD with byte_idx=0 and word_idx=0.
  - WORD:
    - Shift each accepted byte in: word = {word[23:0], byte}; increment byte_idx.
    - On acceptance of the 4th byte, register the strobe for the next cycle with the current word_idx address, then increment word_idx.
    - After the Nth word → CSUM, or → DONE when the checksum is compiled out.
  - CSUM: compare one accepted byte → DONE on match, ERROR on mismatch.
  - DONE: `byte_ready`=0, `done`=1, `cpu_rst`=0. Held until `rst`.
  - ERROR: `byte_ready`=1 (drain), `error`=1, `cpu_rst`=1, `chip_select`=0. Held until `rst`.
- `chip_select`=1 in LEN_HI, LEN_LO, WORD, CSUM and DONE; 0 in IDLE and ERROR.
- `cpu_rst`=1 in every state except DONE.
- `words_loaded` increments once per strobe and never exceeds N.
- Already-written words are not undone on ERROR; memory contents are then undefined for execution.

## Timing
- Reset values:
  - `fetcher_loading`=0, `fetcher_load_inst`=0, `fetcher_load_addr`=0, `chip_select`=0
  - `cpu_rst`=1, `done`=0, `error`=0, `words_loaded`=0
  - `byte_ready`=0 while `rst` is high; 1 (IDLE) the first cycle after.
- Throughput: one byte per cycle. `byte_ready` stays high in WORD, including the cycle of a pending strobe.
- Strobe latency: 4th byte accepted in cycle t → `fetcher_loading`=1 in t+1 only. Inst and addr are stable in t+1.
- Back-to-back words produce strobes spaced exactly 4 cycles apart.
- Release, checksum compiled out: last strobe in t+1, DONE (`cpu_rst`=0, `done`=1) in t+2.
- Release, checksum compiled in: CSUM byte accepted in t → `done`/`error` and the `cpu_rst` transition in t+1.
- `byte_valid` low mid-word: the partial word is held indefinitely, with no timeout.
- Reset mid-frame: partial word, counters and checksum are discarded. Next cycle is IDLE and awaits a new sync byte.
- `SYNC_BYTE` value inside LEN/WORD/CSUM is treated as data, not resync.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - CSUM state present.
  - Checksum = XOR of LEN_HI, LEN_LO and all instruction bytes; the running XOR is cleared on sync.
  - Mismatch → ERROR.
- Undefined:
  - No CSUM byte expected; the frame ends after the last instruction byte.
  - No checksum register is synthesized.
  - ERROR is reachable only via an illegal length.

## Test plan
- Checksum enabled, stream A5 00 02 20 08 00 05 00 00 00 00 2F → strobes at addr 0 with inst 0x20080005 and at addr 4 with inst 0x00000000, 4 cycles apart. Then `done`=1, `cpu_rst`=0, `words_loaded`=2.
- Stream 00 FF 5A A5 00 01 + 4 bytes + csum → leading 3 bytes ignored; one strobe at addr 0; `done`=1.
- A5 00 00 → `error`=1 the cycle after LEN_LO; no strobe; `cpu_rst` stays 1.
- A5 01 01 with MAX_WORDS=256 → `error`=1; `byte_ready` stays 1 and drains further bytes with no strobes.
- Two-word frame with csum byte 0x00 (wrong) → both strobes issued, then `error`=1, `done`=0, `cpu_rst`=1.
- `rst` pulsed after 2 bytes of word 1, then a full valid one-word frame → single strobe at addr 0 with the new data; `words_loaded`=1.

Source files
------------

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction loader. It accepts a framed byte stream on a
// valid/ready port, assembles big-endian 32-bit instructions and writes them
// through the fetcher's load port. The CPU core is held in reset until a
// complete, valid image has been written.
//
// Frame: SYNC_BYTE, LEN_HI, LEN_LO, N*4 instruction bytes (MSB first), and
// a trailing checksum byte when IMEM_LOADER_CHECKSUM_EN is defined. The
// checksum is the XOR of LEN_HI, LEN_LO and every instruction byte.
//
// Build option:
//   IMEM_LOADER_CHECKSUM_EN  adds the CSUM state and the running XOR register.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   byte_valid/ready    byte stream handshake (transfer when both are high)
//   byte_data           byte payload
//   fetcher_loading     one-cycle write strobe to the fetcher
//   fetcher_load_inst   assembled instruction (valid with the strobe)
//   fetcher_load_addr   byte address of the word (word index << 2)
//   chip_select         fetcher enable
//   cpu_rst             reset to the CPU core (released only in DONE)
//   done, error         sticky completion / rejection flags
//   words_loaded        number of strobes issued
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int         MAX_WORDS = 256,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        fetcher_loading,
    output logic [31:0] fetcher_load_inst,
    output logic [31:0] fetcher_load_addr,
    output logic        chip_select,
    output logic        cpu_rst,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_WORD   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        accept_s;
    logic [15:0] len_s;
    logic        last_byte_s;

    logic        ready_r;
    logic        cs_r;
    logic        cpu_rst_r;
    logic        done_r;
    logic        error_r;
    logic        strobe_r;
    logic [31:0] inst_r;
    logic [31:0] addr_r;
    logic [15:0] words_r;
    logic [7:0]  len_hi_r;
    logic [15:0] len_r;
    logic [23:0] word_r;
    logic [1:0]  byte_idx_r;
    logic [15:0] word_idx_r;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_r;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    // ready_r already reflects the current state; rst forces the port low
    // while reset is held so no byte can be taken during reset.
    assign byte_ready        = ready_r & ~rst;
    assign accept_s          = byte_valid & byte_ready;
    assign len_s             = {len_hi_r, byte_data};
    assign last_byte_s       = (byte_idx_r == 2'd3) && (word_idx_r == (len_r - 16'd1));

    assign fetcher_loading   = strobe_r;
    assign fetcher_load_inst = inst_r;
    assign fetcher_load_addr = addr_r;
    assign chip_select       = cs_r;
    assign cpu_rst           = cpu_rst_r;
    assign done              = done_r;
    assign error             = error_r;
    assign words_loaded      = words_r;

    // Next-state logic for the frame parser
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s && (byte_data == SYNC_BYTE)) begin
                    state_s = S_LEN_HI;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LEN_HI: begin
                if (accept_s) begin
                    state_s = S_LEN_LO;
                end else begin
                    state_s = S_LEN_HI;
                end
            end
            S_LEN_LO: begin
                if (!accept_s) begin
                    state_s = S_LEN_LO;
                end else if ((len_s == 16'd0) || (len_s > MAX_LEN)) begin
                    state_s = S_ERROR;
                end else begin
                    state_s = S_WORD;
                end
            end
            S_WORD: begin
                if (accept_s && last_byte_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_s = S_CSUM;
`else
                    state_s = S_DONE;
`endif
                end else begin
                    state_s = S_WORD;
                end
            end
            S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (!accept_s) begin
                    state_s = S_CSUM;
                end else if (byte_data == csum_r) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_ERROR;
                end
`else
                state_s = S_ERROR;
`endif
            end
            S_DONE:  state_s = S_DONE;
            S_ERROR: state_s = S_ERROR;
            default: state_s = S_IDLE;
        endcase
    end

    // State register, word assembly, strobe generation and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            ready_r    <= 1'b1;
            cs_r       <= 1'b0;
            cpu_rst_r  <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            strobe_r   <= 1'b0;
            inst_r     <= 32'd0;
            addr_r     <= 32'd0;
            words_r    <= 16'd0;
            len_hi_r   <= 8'd0;
            len_r      <= 16'd0;
            word_r     <= 24'd0;
            byte_idx_r <= 2'd0;
            word_idx_r <= 16'd0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s != S_DONE);
            cs_r    <= (state_s != S_IDLE) && (state_s != S_ERROR);
            error_r <= (state_s == S_ERROR);
`ifdef IMEM_LOADER_CHECKSUM_EN
            // Release is visible the cycle after the checksum byte.
            done_r    <= (state_s == S_DONE);
            cpu_rst_r <= (state_s != S_DONE);
`else
            // Release trails the last strobe by one cycle, so it follows the
            // registered state rather than the next state.
            done_r    <= (state_r == S_DONE);
            cpu_rst_r <= (state_r != S_DONE);
`endif
            strobe_r <= 1'b0;
            if (accept_s) begin
                case (state_r)
                    S_LEN_HI: len_hi_r <= byte_data;
                    S_LEN_LO: begin
                        len_r      <= len_s;
                        byte_idx_r <= 2'd0;
                        word_idx_r <= 16'd0;
                    end
                    S_WORD: begin
                        word_r     <= {word_r[15:0], byte_data};
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (byte_idx_r == 2'd3) begin
                            strobe_r   <= 1'b1;
                            inst_r     <= {word_r, byte_data};
                            addr_r     <= {14'd0, word_idx_r, 2'b00};
                            word_idx_r <= word_idx_r + 16'd1;
                            words_r    <= words_r + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over length and instruction bytes, restarted on every sync
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_r <= 8'd0;
        end else if (accept_s) begin
            case (state_r)
                S_IDLE:   csum_r <= 8'd0;
                S_LEN_HI: csum_r <= csum_step(csum_r, byte_data);
                S_LEN_LO: csum_r <= csum_step(csum_r, byte_data);
                S_WORD:   csum_r <= csum_step(csum_r, byte_data);
                default:  csum_r <= csum_r;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// Bench for imem_loader. Each frame is parsed up front into a list of
// expected write-port events (which stream byte completes which word, and
// which byte decides done/error); the driver turns those into expected
// cycles as bytes are accepted, and one compare process checks the outputs
// every cycle. Literal checks pin the model on the example frames.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        fetcher_loading;
    logic [31:0] fetcher_load_inst;
    logic [31:0] fetcher_load_addr;
    logic        chip_select;
    logic        cpu_rst;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    imem_loader dut (
        .clk               (clk),
        .rst               (rst),
        .byte_valid        (byte_valid),
        .byte_data         (byte_data),
        .byte_ready        (byte_ready),
        .fetcher_loading   (fetcher_loading),
        .fetcher_load_inst (fetcher_load_inst),
        .fetcher_load_addr (fetcher_load_addr),
        .chip_select       (chip_select),
        .cpu_rst           (cpu_rst),
        .done              (done),
        .error             (error),
        .words_loaded      (words_loaded)
    );

    always #5 clk = ~clk;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int DONE_DLY = 1;
`else
    localparam int DONE_DLY = 2;
`endif
    localparam int NEVER = 1 << 30;

    typedef struct {
        int          cyc;
        logic [31:0] inst;
        logic [31:0] addr;
        int          wl;
    } strobe_t;

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;
    logic [7:0]  stim[$];
    bit          wend[2048];
    logic [31:0] winst[2048];
    logic [31:0] waddr[2048];
    int          rel[2048];
    strobe_t     expq[$];
    logic [31:0] obs_inst[$];
    logic [31:0] obs_addr[$];
    int          obs_cyc[$];
    int          exp_done_cyc = NEVER;
    int          exp_err_cyc = NEVER;
    int          exp_wl = 0;
    int          gap_pos = -1;
    int          gap_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame model: which byte ends which word, and which byte decides the outcome.
    function automatic void plan();
        int s;
        int n;
        int p;
        int sz;
        logic [7:0] x;
        sz = stim.size();
        for (int i = 0; i < sz; i++) begin
            wend[i] = 1'b0;
            rel[i]  = 0;
        end
        s = -1;
        for (int i = 0; i < sz; i++) begin
            if (stim[i] == 8'hA5) begin
                s = i;
                break;
            end
        end
        if (s < 0 || s + 2 >= sz) return;
        n = int'({stim[s+1], stim[s+2]});
        if (n == 0 || n > 256) begin
            rel[s+2] = 2;
            return;
        end
        x = stim[s+1] ^ stim[s+2];
        for (int k = 0; k < n; k++) begin
            p = s + 3 + 4 * k;
            if (p + 3 >= sz) return;
            winst[p+3] = {stim[p], stim[p+1], stim[p+2], stim[p+3]};
            waddr[p+3] = 32'(k * 4);
            wend[p+3]  = 1'b1;
            x = x ^ stim[p] ^ stim[p+1] ^ stim[p+2] ^ stim[p+3];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        p = s + 3 + 4 * n;
        if (p < sz) rel[p] = (stim[p] == x) ? 1 : 2;
`else
        rel[s + 2 + 4 * n] = 1;
`endif
    endfunction

    task automatic note_accept(input int i, input int a);
        if (wend[i]) begin
            exp_wl++;
            expq.push_back('{a + 1, winst[i], waddr[i], exp_wl});
        end
        if (rel[i] == 1) exp_done_cyc = a + DONE_DLY;
        if (rel[i] == 2) exp_err_cyc = a + 1;
    endtask

    task automatic send_stream();
        bit ok;
        plan();
        for (int i = 0; i < stim.size(); i++) begin
            if (i == gap_pos) begin
                byte_valid = 1'b0;
                repeat (gap_len) @(negedge clk);
            end
            byte_valid = 1'b1;
            byte_data  = stim[i];
            ok = 1'b0;
            for (int w = 0; w < 16; w++) begin
                if (byte_ready) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!ok) begin
                n_tests++;
                n_fail++;
                $display("FAIL ready_timeout: byte %0d got ready=0 expected ready=1", i);
                byte_valid = 1'b0;
                return;
            end
            note_accept(i, cyc);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        gap_pos = -1;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        byte_valid = 1'b0;
        byte_data = 8'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready",   32'(byte_ready), 32'd0);
        check("rst_loading", 32'(fetcher_loading), 32'd0);
        check("rst_inst",    fetcher_load_inst, 32'd0);
        check("rst_addr",    fetcher_load_addr, 32'd0);
        check("rst_cs",      32'(chip_select), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_done",    32'(done), 32'd0);
        check("rst_error",   32'(error), 32'd0);
        check("rst_words",   32'(words_loaded), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_ready",  32'(byte_ready), 32'd1);
        expq.delete();
        obs_inst.delete();
        obs_addr.delete();
        obs_cyc.delete();
        stim.delete();
        exp_done_cyc = NEVER;
        exp_err_cyc = NEVER;
        exp_wl = 0;
        chk_en = 1'b1;
    endtask

    task automatic finish_frame();
        repeat (4) @(negedge clk);
        check("pending_strobes", 32'(expq.size()), 32'd0);
        check("words_final", 32'(words_loaded), 32'(exp_wl));
    endtask

    task automatic push_frame(input int n, input logic [31:0] seed);
        logic [7:0]  x;
        logic [31:0] w;
        stim.push_back(8'hA5);
        stim.push_back(n[15:8]);
        stim.push_back(n[7:0]);
        x = n[15:8] ^ n[7:0];
        for (int k = 0; k < n; k++) begin
            w = seed + 32'(k) * 32'h01030507;
            for (int b = 3; b >= 0; b--) begin
                stim.push_back(w[8*b +: 8]);
                x = x ^ w[8*b +: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        stim.push_back(x);
`endif
    endtask

    // Per-cycle comparison of the DUT against the model's expectations
    always @(negedge clk) begin
        bit      dexp;
        bit      eexp;
        strobe_t e;
        if (chk_en) begin
            dexp = (cyc >= exp_done_cyc);
            eexp = (cyc >= exp_err_cyc);
            check("done",    32'(done), 32'(dexp));
            check("error",   32'(error), 32'(eexp));
            check("cpu_rst", 32'(cpu_rst), 32'(!dexp));
            if (eexp) begin
                check("cs_in_error",    32'(chip_select), 32'd0);
                check("ready_in_error", 32'(byte_ready), 32'd1);
            end
            if (dexp) begin
                check("ready_in_done", 32'(byte_ready), 32'd0);
                check("cs_in_done",    32'(chip_select), 32'd1);
            end
            if (fetcher_loading) begin
                if (expq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got strobe addr %h inst %h expected none", fetcher_load_addr, fetcher_load_inst);
                end else begin
                    e = expq.pop_front();
                    check("strobe_cycle", 32'(cyc), 32'(e.cyc));
                    check("strobe_inst",  fetcher_load_inst, e.inst);
                    check("strobe_addr",  fetcher_load_addr, e.addr);
                    check("strobe_words", 32'(words_loaded), 32'(e.wl));
                    obs_inst.push_back(fetcher_load_inst);
                    obs_addr.push_back(fetcher_load_addr);
                    obs_cyc.push_back(cyc);
                end
            end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
                e = expq.pop_front();
                check("strobe_missing", 32'd0, 32'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: two-word example frame
        do_reset();
        stim = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stim.push_back(8'h2F);
`endif
        send_stream();
        finish_frame();
        check("t1_nstrobes", 32'(obs_inst.size()), 32'd2);
        if (obs_inst.size() >= 2) begin
            check("t1_inst0", obs_inst[0], 32'h20080005);
            check("t1_addr0", obs_addr[0], 32'h0);
            check("t1_inst1", obs_inst[1], 32'h00000000);
            check("t1_addr1", obs_addr[1], 32'h4);
            check("t1_spacing", 32'(obs_cyc[1] - obs_cyc[0]), 32'd4);
        end
        check("t1_done", 32'(done), 32'd1);
        check("t1_cpu_rst", 32'(cpu_rst), 32'd0);
        check("t1_words", 32'(words_loaded), 32'd2);

        // 2: leading junk before sync
        do_reset();
        stim = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stim.push_back(8'h23);
`endif
        send_stream();
        finish_frame();
        check("t2_nstrobes", 32'(obs_inst.size()), 32'd1);
        if (obs_inst.size() >= 1) check("t2_inst", obs_inst[0], 32'hDEADBEEF);
        check("t2_done", 32'(done), 32'd1);

        // 3: zero length
        do_reset();
        stim = '{8'hA5, 8'h00, 8'h00};
        send_stream();
        finish_frame();
        check("t3_error", 32'(error), 32'd1);
        check("t3_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t3_nstrobes", 32'(obs_inst.size()), 32'd0);

        // 4: length 257, then drained bytes
        do_reset();
        stim = '{8'hA5, 8'h01, 8'h01, 8'h11, 8'hA5, 8'h22, 8'h33, 8'h44};
        send_stream();
        finish_frame();
        check("t4_error", 32'(error), 32'd1);
        check("t4_ready", 32'(byte_ready), 32'd1);
        check("t4_nstrobes", 32'(obs_inst.size()), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 5: wrong checksum after two words
        do_reset();
        stim = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
        send_stream();
        finish_frame();
        check("t5_error", 32'(error), 32'd1);
        check("t5_done", 32'(done), 32'd0);
        check("t5_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t5_words", 32'(words_loaded), 32'd2);
`endif

        // 6: reset mid-word, then a fresh one-word frame
        do_reset();
        stim = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22};
        send_stream();
        do_reset();
        stim = '{8'hA5, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stim.push_back(8'hC8);
`endif
        send_stream();
        finish_frame();
        check("t6_nstrobes", 32'(obs_inst.size()), 32'd1);
        if (obs_inst.size() >= 1) begin
            check("t6_inst", obs_inst[0], 32'hCAFEF00D);
            check("t6_addr", obs_addr[0], 32'h0);
        end
        check("t6_words", 32'(words_loaded), 32'd1);

        // 7: sync value as data, with valid low mid-word
        do_reset();
        stim = '{8'hA5, 8'h00, 8'h02, 8'hA5, 8'hA5, 8'h00, 8'h01, 8'h00, 8'hA5, 8'h00, 8'hA5};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stim.push_back(8'h02 ^ 8'h01);
`endif
        gap_pos = 5;
        gap_len = 6;
        send_stream();
        finish_frame();
        check("t7_nstrobes", 32'(obs_inst.size()), 32'd2);
        if (obs_inst.size() >= 2) begin
            check("t7_inst0", obs_inst[0], 32'hA5A50001);
            check("t7_inst1", obs_inst[1], 32'h00A500A5);
        end
        check("t7_done", 32'(done), 32'd1);

        // 8: maximum legal length
        do_reset();
        push_frame(256, 32'h13579BDF);
        send_stream();
        finish_frame();
        check("t8_words", 32'(words_loaded), 32'd256);
        check("t8_done", 32'(done), 32'd1);
        check("t8_last_addr", fetcher_load_addr, 32'h3FC);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
